// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore sequencer for the multi-cycle RV32I core.
// Steps fetch / decode / execute / memory / writeback one micro-step per
// cycle and drives every datapath enable, mux select and ALU operation.
// Also holds alu_decoder, which maps alu_op/funct3/funct7/op[5] onto the
// 3-bit ALU control code.

module alu_decoder (
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       opb5,
  output logic [2:0] alu_control
);

  // Only funct7[5] separates add from sub; the other bits are folded here
  // so they are not left dangling.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // ALU control: 000 add, 001 sub, 010 and, 011 or, 101 slt
  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b00:   alu_control = 3'b000;
      2'b01:   alu_control = 3'b001;
      default: begin
        case (funct3)
          3'b000:  alu_control = (funct7[5] & opb5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
    endcase
  end

endmodule

module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       instr_done,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;

  // State register; reset always returns to FETCH
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Per-state outputs and next state; reset masks every strobe and shows
  // the FETCH selects so the datapath sees a benign configuration.
  always_comb begin
    state_d    = S_FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_update = 1'b1;
          state_d   = S_DECODE;
        end else begin
          state_d   = S_FETCH;
        end
      end
      S_DECODE: begin
        // old_pc + imm lands in alu_out for a possible branch
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        // strobe held for the whole wait so memory sees a stable request
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d    = S_MEMWRITE;
        end
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        // PC <- target held in alu_out while ALU forms old_pc + 4 as link
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    pc_write = pc_update | (branch & zero);

    if (rst) begin
      state_d    = S_FETCH;
      pc_write   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      adr_src    = 1'b0;
      result_src = 2'b10;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b10;
      alu_op     = 2'b00;
    end
  end

  // Immediate format follows the opcode regardless of state
  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7      (funct7),
    .opb5        (op[5]),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: every instruction is expanded into the
// list of per-cycle output vectors its micro-steps must produce, with
// random memory wait counts, random funct fields and random values on
// inputs the controller must ignore.

module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       instr_done, illegal_op;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       instr_done;
    logic       illegal_op;
  } out_t;

  out_t act;
  assign act = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                alu_src_a, alu_src_b, imm_src, alu_control, instr_done, illegal_op};

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011, SLT = 3'b101;

  int vectors = 0;
  int miscompares = 0;
  int retired = 0;

  function automatic logic is_legal(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == JL) || (o == BQ);
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  // RV32I meaning of funct3 (and funct7 for R-type sub)
  function automatic logic [2:0] funct_alu();
    if (funct3 == 3'b010) return SLT;
    if (funct3 == 3'b110) return OR_;
    if (funct3 == 3'b111) return AND_;
    if (funct3 == 3'b000 && op == RT && funct7 == 7'b0100000) return SUB;
    return ADD;
  endfunction

  function automatic out_t base();
    out_t e;
    e = '0;
    e.imm_src = imm_of(op);
    return e;
  endfunction

  // FETCH look: PC on the address bus, PC + 4 on the ALU
  function automatic out_t e_fetch(input logic go);
    out_t e;
    e = base();
    e.alu_src_b  = 2'b10;
    e.result_src = 2'b10;
    e.alu_control = ADD;
    e.ir_write = go;
    e.pc_write = go;
    return e;
  endfunction

  function automatic out_t e_step(input string kind, input logic flag);
    out_t e;
    e = base();
    case (kind)
      "decode":   begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; e.illegal_op = flag; end
      "memadr":   begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
      "memread":  begin e.adr_src = 1'b1; end
      "memwb":    begin e.result_src = 2'b01; e.reg_write = 1'b1; e.instr_done = 1'b1; end
      "memwrite": begin e.adr_src = 1'b1; e.mem_write = 1'b1; e.instr_done = flag; end
      "executer": begin e.alu_src_a = 2'b10; e.alu_control = funct_alu(); end
      "executei": begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_control = funct_alu(); end
      "aluwb":    begin e.reg_write = 1'b1; e.instr_done = 1'b1; end
      "jal":      begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1; end
      "beq":      begin e.alu_src_a = 2'b10; e.alu_control = SUB; e.pc_write = flag; e.instr_done = 1'b1; end
      default:    e = base();
    endcase
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Apply inputs for one cycle, compare on the falling edge, then advance
  task automatic cyc(input out_t exp, input logic mr, input logic z, input string tag);
    mem_ready = mr;
    zero      = z;
    @(negedge clk);
    vectors++;
    if (act.instr_done === 1'b1) retired++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s op=%b observed=%h expected=%h", tag, op, act, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                           input logic z, input int fw, input int mw);
    op = o; funct3 = f3; funct7 = f7;
    for (int i = 0; i < fw; i++) cyc(e_fetch(1'b0), 1'b0, rb(), "fetch_wait");
    cyc(e_fetch(1'b1), 1'b1, rb(), "fetch");
    cyc(e_step("decode", !is_legal(o)), rb(), rb(), "decode");
    if (o == LW) begin
      cyc(e_step("memadr", 1'b0), rb(), rb(), "memadr");
      for (int i = 0; i < mw; i++) cyc(e_step("memread", 1'b0), 1'b0, rb(), "memread_wait");
      cyc(e_step("memread", 1'b0), 1'b1, rb(), "memread");
      cyc(e_step("memwb", 1'b0), rb(), rb(), "memwb");
    end else if (o == SW) begin
      cyc(e_step("memadr", 1'b0), rb(), rb(), "memadr");
      for (int i = 0; i < mw; i++) cyc(e_step("memwrite", 1'b0), 1'b0, rb(), "memwrite_wait");
      cyc(e_step("memwrite", 1'b1), 1'b1, rb(), "memwrite");
    end else if (o == RT) begin
      cyc(e_step("executer", 1'b0), rb(), rb(), "executer");
      cyc(e_step("aluwb", 1'b0), rb(), rb(), "aluwb");
    end else if (o == IT) begin
      cyc(e_step("executei", 1'b0), rb(), rb(), "executei");
      cyc(e_step("aluwb", 1'b0), rb(), rb(), "aluwb");
    end else if (o == JL) begin
      cyc(e_step("jal", 1'b0), rb(), rb(), "jal");
      cyc(e_step("aluwb", 1'b0), rb(), rb(), "aluwb");
    end else if (o == BQ) begin
      cyc(e_step("beq", z), rb(), z, "beq");
    end
  endtask

  logic [2:0] f3_tab [4] = '{3'b000, 3'b010, 3'b110, 3'b111};
  logic [6:0] op_tab [6] = '{LW, SW, RT, IT, JL, BQ};

  initial begin
    logic [6:0] o;
    int expected_retired;
    rst = 1'b1; op = 7'd0; funct3 = 3'd0; funct7 = 7'd0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    cyc(e_fetch(1'b0), 1'b1, 1'b1, "reset0");
    cyc(e_fetch(1'b0), 1'b1, 1'b1, "reset1");
    rst = 1'b0;

    // directed instructions
    run_instr(LW, 3'b010, 7'd0, 1'b0, 0, 0);
    run_instr(SW, 3'b010, 7'd0, 1'b0, 0, 2);
    run_instr(BQ, 3'b000, 7'd0, 1'b1, 0, 0);
    run_instr(BQ, 3'b000, 7'd0, 1'b0, 0, 0);
    run_instr(JL, 3'b000, 7'd0, 1'b0, 0, 0);
    run_instr(RT, 3'b000, 7'b0100000, 1'b0, 0, 0);
    run_instr(IT, 3'b000, 7'b0100000, 1'b0, 0, 0);
    run_instr(7'b1111111, 3'b000, 7'd0, 1'b0, 0, 0);
    expected_retired = 7;

    // reset arriving in EXECUTER aborts the R-type instruction
    op = RT; funct3 = 3'b000; funct7 = 7'd0;
    cyc(e_fetch(1'b1), 1'b1, 1'b0, "abort_fetch");
    cyc(e_step("decode", 1'b0), 1'b1, 1'b0, "abort_decode");
    rst = 1'b1;
    cyc(e_fetch(1'b0), 1'b1, 1'b1, "rst_mid0");
    cyc(e_fetch(1'b0), 1'b1, 1'b1, "rst_mid1");
    rst = 1'b0;
    run_instr(LW, 3'b010, 7'd0, 1'b0, 1, 1);
    expected_retired++;

    // randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      int k;
      k = int'($urandom_range(0, 6));
      if (k < 6) begin
        o = op_tab[k];
        expected_retired++;
      end else begin
        o = 7'b1111111;
        for (int t = 0; t < 10; t++) begin
          logic [6:0] c;
          c = 7'($urandom_range(0, 127));
          if (!is_legal(c)) begin o = c; break; end
        end
      end
      run_instr(o, f3_tab[$urandom_range(0, 3)], rb() ? 7'b0100000 : 7'b0000000,
                rb(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    vectors++;
    assert (retired === expected_retired) else begin
      miscompares++;
      $error("FAIL instr_done_count observed=%0d expected=%0d", retired, expected_retired);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for the multi-cycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal). It holds a 4-bit Moore state machine and steps the shared datapath one micro-step per cycle: fetch through a single unified memory port, decode, execute, memory access and writeback. Every datapath enable, mux select and ALU operation comes from this block. ALU operation decode is done by the existing `alu_decoder`, instantiated inside this block and fed from `alu_op`, `funct3`, `funct7` and `op[5]`.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op` in 7: opcode of the instruction register.
- `funct3` in 3: instruction register bits [14:12].
- `funct7` in 7: instruction register bits [31:25].
- `zero` in 1: ALU zero flag for the current cycle.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write` out 1: PC register load enable.
- `adr_src` out 1: memory address select. 0 = PC, 1 = result.
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: loads the instruction register and old_pc.
- `reg_write` out 1: register file write enable.
- `result_src` out 2: result mux. 00 = alu_out reg, 01 = mem data reg, 10 = live ALU result.
- `alu_src_a` out 2: ALU A select. 00 = PC, 01 = old_pc, 10 = rs1 reg.
- `alu_src_b` out 2: ALU B select. 00 = rs2 reg, 01 = immediate, 10 = constant 4.
- `imm_src` out 2: immediate format. 00 = I, 01 = S, 10 = B, 11 = J.
- `alu_control` out 3: from `alu_decoder`.
- `instr_done` out 1: one-cycle pulse when an instruction retires.
- `illegal_op` out 1: one-cycle pulse in DECODE when the opcode is unsupported.

## Operation
- State encoding: FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECUTER = 6, ALUWB = 7, EXECUTEI = 8, JAL = 9, BEQ = 10. Codes 11–15 go to FETCH on the next cycle.
- `alu_op` is internal. 00 = add, 01 = sub, 10 = funct-decoded.
- Unless listed for a state below, every output is 0.

Per-state outputs and transitions:
- FETCH
  - Outputs: adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu_op = 00, result_src = 10.
  - When `mem_ready` = 1: ir_write = 1, pc_update = 1, go to DECODE.
  - Otherwise stay in FETCH with ir_write = 0 and pc_update = 0.
- DECODE
  - Outputs: alu_src_a = 01, alu_src_b = 01, alu_op = 00. This computes the branch target into alu_out.
  - Next state by `op`: 0000011 or 0100011 → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1101111 → JAL; 1100011 → BEQ.
  - Any other opcode → FETCH, with `illegal_op` = 1.
- MEMADR
  - Outputs: alu_src_a = 10, alu_src_b = 01, alu_op = 00.
  - Next: MEMREAD if op = 0000011, else MEMWRITE.
- MEMREAD
  - Outputs: adr_src = 1, result_src = 00.
  - Stays until `mem_ready`, then MEMWB.
- MEMWB
  - Outputs: result_src = 01, reg_write = 1, instr_done = 1.
  - Next: FETCH.
- MEMWRITE
  - Outputs: adr_src = 1, result_src = 00, mem_write = 1. mem_write stays asserted through the wait.
  - On the `mem_ready` cycle: instr_done = 1, go to FETCH.
- EXECUTER
  - Outputs: alu_src_a = 10, alu_src_b = 00, alu_op = 10.
  - Next: ALUWB.
- EXECUTEI
  - Outputs: alu_src_a = 10, alu_src_b = 01, alu_op = 10.
  - Next: ALUWB.
- ALUWB
  - Outputs: result_src = 00, reg_write = 1, instr_done = 1.
  - Next: FETCH.
- JAL
  - Outputs: alu_src_a = 01, alu_src_b = 10, alu_op = 00, result_src = 00, pc_update = 1.
  - Next: ALUWB.
- BEQ
  - Outputs: alu_src_a = 10, alu_src_b = 00, alu_op = 01, result_src = 00, branch = 1, instr_done = 1.
  - Next: FETCH.

Combinational rules:
- `pc_write` = pc_update | (branch & zero).
- `imm_src` decodes from `op` in every state: sw → 01, beq → 10, jal → 11, all others → 00.

## Timing
- On a clock edge with `rst` = 1, the state register loads FETCH.
- While `rst` = 1, all write enables, `instr_done` and `illegal_op` are forced to 0. Select outputs show their FETCH values.
- Reset asserted mid-instruction aborts the instruction. No write enable is asserted in the reset cycle. FETCH is entered on the next edge.
- Outputs are combinational from the state register and the listed inputs. There is no registered output stage.
- Latency with `mem_ready` held at 1:
  - lw: 5 cycles.
  - sw, R-type, I-type, jal: 4 cycles.
  - beq: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each memory wait cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- `mem_ready` is sampled only in FETCH, MEMREAD and MEMWRITE; it is ignored in all other states.
- `zero` is sampled only in BEQ, in the same cycle.
- `instr_done` pulses exactly once per retired instruction, in its last cycle.

## Test plan
- Reset: rst = 1 for 2 cycles while in EXECUTER → all enables 0 during reset. After release: FETCH, adr_src = 0, alu_src_b = 10; ir_write = 1 and pc_write = 1 on the first cycle.
- lw, op = 0000011, mem_ready = 1 → states 0, 1, 2, 3, 4. reg_write = 1 with result_src = 01 in cycle 5 only. instr_done = 1 in cycle 5.
- sw, op = 0100011, mem_ready low for 2 cycles in MEMWRITE → mem_write = 1 for 3 cycles, adr_src = 1, imm_src = 01. instr_done pulses on the ready cycle, then FETCH.
- beq, op = 1100011: zero = 1 → pc_write = 1 in BEQ with alu_op = 01. zero = 0 → pc_write = 0. Both cases take 3 cycles.
- jal, op = 1101111 → JAL asserts pc_write = 1 with alu_src_a = 01 and alu_src_b = 10. ALUWB then asserts reg_write = 1. imm_src = 11 throughout.
- R-type add/sub: funct3 = 000, funct7 = 0100000 → alu_control = sub in EXECUTER. Illegal opcode 1111111 → illegal_op pulse in DECODE, back to FETCH, no write enables asserted.
